cosim_ep_mux: RTL and testbench

COSIM_EP_MUX -- requirements
Module: cosim_ep_mux

---
 rtl/cosim_ep_mux_pkg.sv | 16 +
 rtl/cosim_ep_mux_if.sv | 35 +++
 rtl/cosim_ep_mux_rr_arbiter.sv | 33 +++
 rtl/cosim_ep_mux.sv | 132 +++++++++++++
 tb/tb_cosim_ep_mux.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cosim_ep_mux_pkg.sv
// Shared types and constants for the cosim endpoint multiplexer.
package CosimMuxPkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } req_state_e;

  localparam int unsigned BAD_TAG_CNT_W = 16;

  // Saturating increment for the dropped-response counter.
  function automatic logic [BAD_TAG_CNT_W-1:0] sat_inc(input logic [BAD_TAG_CNT_W-1:0] v);
    return (&v) ? v : v + BAD_TAG_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cosim_ep_mux_if.sv
// Channel-side and endpoint-side signal bundle of the cosim endpoint multiplexer.
interface cosim_ep_mux_if
  import CosimMuxPkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PAYLOAD_BITS = 32
);
  localparam int unsigned TAG_BITS = $clog2(NUM_CH);
  localparam int unsigned MSG_BITS = TAG_BITS + PAYLOAD_BITS;

  logic [NUM_CH-1:0]              ReqValid;
  logic [NUM_CH-1:0]              ReqReady;
  logic [NUM_CH*PAYLOAD_BITS-1:0] ReqData;
  logic                           EpInValid;
  logic                           EpInReady;
  logic [MSG_BITS-1:0]            EpInData;
  logic                           EpOutValid;
  logic                           EpOutReady;
  logic [MSG_BITS-1:0]            EpOutData;
  logic [NUM_CH-1:0]              RspValid;
  logic [NUM_CH-1:0]              RspReady;
  logic [PAYLOAD_BITS-1:0]        RspData;
  logic [BAD_TAG_CNT_W-1:0]       BadTagCount;

  modport master (
    output ReqValid, ReqData, EpInReady, EpOutValid, EpOutData, RspReady,
    input  ReqReady, EpInValid, EpInData, EpOutReady, RspValid, RspData, BadTagCount
  );

  modport slave (
    input  ReqValid, ReqData, EpInReady, EpOutValid, EpOutData, RspReady,
    output ReqReady, EpInValid, EpInData, EpOutReady, RspValid, RspData, BadTagCount
  );

endinterface

// File: rtl/cosim_ep_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module cosim_rr_arbiter #(
  parameter  int unsigned NUM_CH   = 4,
  localparam int unsigned TAG_BITS = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [TAG_BITS-1:0] ptr_i,
  output logic [NUM_CH-1:0]   gnt_oh_c,
  output logic [TAG_BITS-1:0] gnt_idx_c,
  output logic                any_gnt_c
);

  always_comb begin
    int unsigned         idx;
    logic [TAG_BITS-1:0] sel;
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    any_gnt_c = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = TAG_BITS'(idx);
      if (!any_gnt_c && req_i[sel]) begin
        any_gnt_c     = 1'b1;
        gnt_idx_c     = sel;
        gnt_oh_c[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cosim_ep_mux.sv
// Funnels NUM_CH requesters into one tagged endpoint stream and routes tagged
// endpoint responses back to the owning channel.
module cosim_ep_mux
  import CosimMuxPkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PAYLOAD_BITS = 32
) (
  input  logic         clk,
  input  logic         rstn,
  cosim_ep_mux_if.slave bus
);

  localparam int unsigned TAG_BITS = $clog2(NUM_CH);
  localparam int unsigned MSG_BITS = TAG_BITS + PAYLOAD_BITS;

  req_state_e                state_q, state_d;
  logic [TAG_BITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TAG_BITS-1:0]       gnt_q, gnt_d;
  logic [MSG_BITS-1:0]       req_msg_q, req_msg_d;
  logic                      full_q, full_d;
  logic [TAG_BITS-1:0]       rsp_tag_q, rsp_tag_d;
  logic [PAYLOAD_BITS-1:0]   rsp_pay_q, rsp_pay_d;
  logic [BAD_TAG_CNT_W-1:0]  bad_cnt_q, bad_cnt_d;

  logic [NUM_CH-1:0]         arb_oh;
  logic [TAG_BITS-1:0]       arb_idx;
  logic                      arb_any;
  logic [PAYLOAD_BITS-1:0]   req_payload;
  logic [NUM_CH-1:0]         req_ready_c;
  logic                      ep_in_valid_c;
  logic [TAG_BITS-1:0]       out_tag;
  logic [PAYLOAD_BITS-1:0]   out_pay;

  cosim_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req_i     (bus.ReqValid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_c  (arb_oh),
    .gnt_idx_c (arb_idx),
    .any_gnt_c (arb_any)
  );

  // Payload of the channel the arbiter currently picks.
  always_comb begin
    req_payload = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(arb_idx) == i) req_payload = bus.ReqData[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Request FSM: grant in IDLE, present the held message in HOLD.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    req_msg_d     = req_msg_q;
    req_ready_c   = '0;
    ep_in_valid_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready_c = arb_oh;
          req_msg_d   = {arb_idx, req_payload};
          gnt_d       = arb_idx;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        ep_in_valid_c = 1'b1;
        if (bus.EpInReady) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (gnt_q == TAG_BITS'(NUM_CH - 1)) ? '0 : gnt_q + TAG_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_tag = bus.EpOutData[MSG_BITS-1 -: TAG_BITS];
  assign out_pay = bus.EpOutData[PAYLOAD_BITS-1:0];

  // Single-entry response buffer; out-of-range tags are dropped and counted.
  always_comb begin
    full_d    = full_q;
    rsp_tag_d = rsp_tag_q;
    rsp_pay_d = rsp_pay_q;
    bad_cnt_d = bad_cnt_q;
    if (full_q) begin
      if (bus.RspReady[rsp_tag_q]) full_d = 1'b0;
    end else if (bus.EpOutValid) begin
      if (32'(out_tag) < NUM_CH) begin
        full_d    = 1'b1;
        rsp_tag_d = out_tag;
        rsp_pay_d = out_pay;
      end else begin
        bad_cnt_d = sat_inc(bad_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      req_msg_q <= '0;
      full_q    <= 1'b0;
      rsp_tag_q <= '0;
      rsp_pay_q <= '0;
      bad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      req_msg_q <= req_msg_d;
      full_q    <= full_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_pay_q <= rsp_pay_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

  // Handshake outputs are forced idle while reset is asserted.
  assign bus.ReqReady    = rstn ? req_ready_c : '0;
  assign bus.EpInValid   = rstn & ep_in_valid_c;
  assign bus.EpInData    = rstn ? req_msg_q : '0;
  assign bus.EpOutReady  = rstn & ~full_q;
  assign bus.RspValid    = (rstn && full_q) ? (NUM_CH'(1) << rsp_tag_q) : '0;
  assign bus.RspData     = (rstn && full_q) ? rsp_pay_q : '0;
  assign bus.BadTagCount = bad_cnt_q;

endmodule

// File: tb/tb_cosim_ep_mux.sv
// Self-checking bench for cosim_ep_mux: arbitration table, directed corner
// sequences, randomized traffic against a queue model, and bad-tag saturation.
module tb_cosim_ep_mux;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cosim_ep_mux_if #(.NUM_CH(4), .PAYLOAD_BITS(32)) b4 ();
  cosim_ep_mux_if #(.NUM_CH(3), .PAYLOAD_BITS(32)) b3 ();

  cosim_ep_mux #(.NUM_CH(4), .PAYLOAD_BITS(32)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));
  cosim_ep_mux #(.NUM_CH(3), .PAYLOAD_BITS(32)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));

  typedef struct {
    logic [3:0] vld;
    logic [3:0] exp_rdy;
    logic [1:0] exp_tag;
  } arb_vec_t;

  arb_vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pay(input int ch);
    return 32'hA5A5_0000 + 32'(ch);
  endfunction

  task automatic set_pay4();
    for (int i = 0; i < 4; i++) b4.ReqData[i*32 +: 32] = pay(i);
  endtask

  task automatic idle_all();
    b4.ReqValid = '0; b4.ReqData = '0; b4.EpInReady = 1'b0;
    b4.EpOutValid = 1'b0; b4.EpOutData = '0; b4.RspReady = '0;
    b3.ReqValid = '0; b3.ReqData = '0; b3.EpInReady = 1'b0;
    b3.EpOutValid = 1'b0; b3.EpOutData = '0; b3.RspReady = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_all();
    #1 chk("rst_epoutready_low", 64'(b4.EpOutReady), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic run_random(input int cycles);
    int m_busy, m_gnt, m_ptr, m_full, m_rtag, m_bad, sel, c, t;
    logic [33:0] m_msg;
    logic [31:0] m_rpay;
    logic [3:0]  exp_rdy;
    m_busy = 0; m_gnt = 0; m_ptr = 0; m_full = 0; m_rtag = 0; m_bad = 0;
    m_msg = '0; m_rpay = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      b4.ReqValid = 4'($urandom);
      for (int i = 0; i < 4; i++) b4.ReqData[i*32 +: 32] = $urandom;
      b4.EpInReady  = 1'($urandom);
      b4.EpOutValid = 1'($urandom);
      b4.EpOutData  = {2'($urandom), 32'($urandom)};
      b4.RspReady   = 4'($urandom);
      #1;
      sel = -1;
      if (m_busy == 0) begin
        for (int i = 0; i < 4; i++) begin
          c = (m_ptr + i) % 4;
          if (sel < 0 && b4.ReqValid[c]) sel = c;
        end
      end
      exp_rdy = (sel < 0) ? 4'b0000 : (4'b0001 << sel);
      chk("rnd_reqready", 64'(b4.ReqReady), 64'(exp_rdy));
      chk("rnd_epinvalid", 64'(b4.EpInValid), 64'(m_busy));
      if (m_busy != 0) chk("rnd_epindata", 64'(b4.EpInData), 64'(m_msg));
      chk("rnd_epoutready", 64'(b4.EpOutReady), 64'(m_full == 0));
      chk("rnd_rspvalid", 64'(b4.RspValid), (m_full != 0) ? 64'(4'b0001 << m_rtag) : 64'(0));
      if (m_full != 0) chk("rnd_rspdata", 64'(b4.RspData), 64'(m_rpay));
      chk("rnd_badcount", 64'(b4.BadTagCount), 64'(m_bad));
      // advance the model to the state after the coming clock edge
      if (m_busy != 0) begin
        if (b4.EpInReady) begin
          m_busy = 0;
          m_ptr  = (m_gnt + 1) % 4;
        end
      end else if (sel >= 0) begin
        m_busy = 1;
        m_gnt  = sel;
        m_msg  = {2'(sel), b4.ReqData[sel*32 +: 32]};
      end
      if (m_full != 0) begin
        if (b4.RspReady[m_rtag]) m_full = 0;
      end else if (b4.EpOutValid) begin
        t = int'(b4.EpOutData[33:32]);
        if (t < 4) begin
          m_full = 1; m_rtag = t; m_rpay = b4.EpOutData[31:0];
        end else if (m_bad < 65535) m_bad++;
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    logic [3:0] oh;
    int g;
    rstn = 1'b0;
    idle_all();

    tbl[0] = '{4'b0001, 4'b0001, 2'd0};
    tbl[1] = '{4'b0001, 4'b0001, 2'd0};
    tbl[2] = '{4'b1010, 4'b0010, 2'd1};
    tbl[3] = '{4'b1010, 4'b1000, 2'd3};
    tbl[4] = '{4'b0110, 4'b0010, 2'd1};
    tbl[5] = '{4'b0000, 4'b0000, 2'd0};
    tbl[6] = '{4'b0011, 4'b0001, 2'd0};
    tbl[7] = '{4'b1100, 4'b0100, 2'd2};
    tbl[8] = '{4'b1111, 4'b1000, 2'd3};

    // Reset values
    do_reset();
    chk("rst_reqready", 64'(b4.ReqReady), 64'(0));
    chk("rst_epinvalid", 64'(b4.EpInValid), 64'(0));
    chk("rst_epindata", 64'(b4.EpInData), 64'(0));
    chk("rst_epoutready", 64'(b4.EpOutReady), 64'(1));
    chk("rst_rspvalid", 64'(b4.RspValid), 64'(0));
    chk("rst_rspdata", 64'(b4.RspData), 64'(0));
    chk("rst_badcount", 64'(b4.BadTagCount), 64'(0));

    // Arbitration table
    set_pay4();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b4.ReqValid = tbl[k].vld;
      b4.EpInReady = 1'b0;
      #1 chk("arb_ready", 64'(b4.ReqReady), 64'(tbl[k].exp_rdy));
      @(negedge clk);
      b4.ReqValid = '0;
      #1;
      if (tbl[k].exp_rdy != 4'b0000) begin
        chk("arb_valid", 64'(b4.EpInValid), 64'(1));
        chk("arb_data", 64'(b4.EpInData), 64'({tbl[k].exp_tag, pay(int'(tbl[k].exp_tag))}));
        b4.EpInReady = 1'b1;
        @(negedge clk);
        b4.EpInReady = 1'b0;
      end else begin
        chk("arb_novalid", 64'(b4.EpInValid), 64'(0));
      end
    end

    // All channels valid, endpoint always ready: tags rotate every other cycle
    do_reset();
    for (int i = 0; i < 4; i++) b4.ReqData[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    @(negedge clk);
    b4.ReqValid = 4'b1111;
    b4.EpInReady = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      g = (cyc / 2) % 4;
      oh = 4'b0001 << g;
      if (cyc % 2 == 0) begin
        chk("rot_ready", 64'(b4.ReqReady), 64'(oh));
        chk("rot_idle_valid", 64'(b4.EpInValid), 64'(0));
      end else begin
        chk("rot_valid", 64'(b4.EpInValid), 64'(1));
        chk("rot_ready_hold", 64'(b4.ReqReady), 64'(0));
        chk("rot_data", 64'(b4.EpInData), 64'({2'(g), 32'hC0DE_0000 + 32'(g)}));
      end
      @(negedge clk);
    end
    b4.ReqValid = '0;
    b4.EpInReady = 1'b0;

    // Endpoint back-pressure holds the message stable
    do_reset();
    @(negedge clk);
    b4.ReqValid = 4'b0100;
    b4.ReqData[64 +: 32] = 32'hDEAD_BEEF;
    #1 chk("hold_grant", 64'(b4.ReqReady), 64'(4'b0100));
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 64'(b4.EpInValid), 64'(1));
      chk("hold_data", 64'(b4.EpInData), 64'({2'd2, 32'hDEAD_BEEF}));
      chk("hold_ready_low", 64'(b4.ReqReady), 64'(0));
    end
    @(negedge clk);
    b4.EpInReady = 1'b1;
    b4.ReqValid = '0;
    @(negedge clk);
    b4.EpInReady = 1'b0;
    #1 chk("hold_released", 64'(b4.EpInValid), 64'(0));

    // Response held until owning channel accepts; other readies ignored
    @(negedge clk);
    b4.EpOutValid = 1'b1;
    b4.EpOutData = {2'd3, 32'h1234_5678};
    b4.RspReady = 4'b0111;
    #1 chk("rsp_accept", 64'(b4.EpOutReady), 64'(1));
    @(negedge clk);
    b4.EpOutData = {2'd0, 32'hFFFF_0000};
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      chk("rsp_valid", 64'(b4.RspValid), 64'(4'b1000));
      chk("rsp_data", 64'(b4.RspData), 64'(32'h1234_5678));
      chk("rsp_full", 64'(b4.EpOutReady), 64'(0));
      @(negedge clk);
    end
    b4.RspReady = 4'b1000;
    b4.EpOutValid = 1'b0;
    #1 chk("rsp_pulse_valid", 64'(b4.RspValid), 64'(4'b1000));
    @(negedge clk);
    b4.RspReady = '0;
    #1;
    chk("rsp_cleared", 64'(b4.RspValid), 64'(0));
    chk("rsp_ready_again", 64'(b4.EpOutReady), 64'(1));

    // Reset while HOLD and response full
    do_reset();
    set_pay4();
    @(negedge clk);
    b4.ReqValid = 4'b0100;
    @(negedge clk);
    b4.ReqValid = '0;
    b4.EpInReady = 1'b1;
    @(negedge clk);
    b4.EpInReady = 1'b0;
    b4.ReqValid = 4'b0010;
    b4.EpOutValid = 1'b1;
    b4.EpOutData = {2'd1, 32'h0BAD_F00D};
    @(negedge clk);
    b4.ReqValid = '0;
    b4.EpOutValid = 1'b0;
    #1;
    chk("mid_hold", 64'(b4.EpInValid), 64'(1));
    chk("mid_full", 64'(b4.RspValid), 64'(4'b0010));
    rstn = 1'b0;
    #1;
    chk("mid_rst_epoutready", 64'(b4.EpOutReady), 64'(0));
    chk("mid_rst_reqready", 64'(b4.ReqReady), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_valid", 64'(b4.EpInValid), 64'(0));
    chk("post_rst_rspvalid", 64'(b4.RspValid), 64'(0));
    chk("post_rst_epoutready", 64'(b4.EpOutReady), 64'(1));
    chk("post_rst_data", 64'(b4.EpInData), 64'(0));
    b4.ReqValid = 4'b1010;
    #1 chk("post_rst_grant", 64'(b4.ReqReady), 64'(4'b0010));
    @(negedge clk);
    b4.ReqValid = '0;
    #1 chk("post_rst_msg", 64'(b4.EpInData), 64'({2'd1, pay(1)}));
    b4.EpInReady = 1'b1;
    @(negedge clk);
    b4.EpInReady = 1'b0;

    // Randomized traffic against the model
    do_reset();
    run_random(3000);

    // NUM_CH=3: good tag routes, tag 3 is dropped and counted to saturation
    do_reset();
    @(negedge clk);
    b3.EpOutValid = 1'b1;
    b3.EpOutData = {2'd2, 32'h0000_0022};
    @(negedge clk);
    b3.EpOutValid = 1'b0;
    #1;
    chk("n3_good_valid", 64'(b3.RspValid), 64'(3'b100));
    chk("n3_good_data", 64'(b3.RspData), 64'(32'h22));
    b3.RspReady = 3'b100;
    @(negedge clk);
    b3.RspReady = '0;
    b3.EpOutValid = 1'b1;
    b3.EpOutData = {2'd3, 32'h0000_0001};
    #1;
    chk("n3_bad_ready", 64'(b3.EpOutReady), 64'(1));
    chk("n3_bad_cnt0", 64'(b3.BadTagCount), 64'(0));
    @(negedge clk);
    #1;
    chk("n3_bad_cnt1", 64'(b3.BadTagCount), 64'(1));
    chk("n3_bad_novalid", 64'(b3.RspValid), 64'(0));
    chk("n3_bad_stay_empty", 64'(b3.EpOutReady), 64'(1));
    repeat (65533) @(negedge clk);
    #1 chk("n3_cnt_fffe", 64'(b3.BadTagCount), 64'(16'hFFFE));
    @(negedge clk);
    #1 chk("n3_cnt_ffff", 64'(b3.BadTagCount), 64'(16'hFFFF));
    repeat (5) @(negedge clk);
    #1 chk("n3_cnt_sat", 64'(b3.BadTagCount), 64'(16'hFFFF));
    b3.EpOutValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
